// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU memory/bus controller:
// region and state encodings, IO register offsets, default IO window base.
package mem_map_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_IO
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM,
        ST_ROM,
        ST_IO,
        ST_ACK
    } state_e;

    localparam logic [3:0] IO_GPIO_OUT = 4'h0;
    localparam logic [3:0] IO_GPIO_IN  = 4'h1;
    localparam logic [3:0] IO_TIMER    = 4'h2;

    localparam logic [15:0] IO_BASE_DEF = 16'hFFF0;

    function automatic region_e decode_region(
        input logic [15:0] addr,
        input logic [15:0] io_base
    );
        if (!addr[15])
            return REG_RAM;
        else if (addr >= io_base)
            return REG_IO;
        else
            return REG_ROM;
    endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM, 2^AW x 8; a read in the same cycle as a
// write to that address returns the old contents.
module mem_ram_sp #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory/bus controller: RAM, wait-stated ROM and IO registers behind
// a req/ack handshake. Define MEM_BUS_TIMER_EN to add the IO timer.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int          RAM_AW   = 15,
    parameter int          ROM_WAIT = 2,
    parameter logic [15:0] IO_BASE  = IO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        bus_err,
    output logic [14:0] rom_addr,
    output logic        rom_rd,
    input  logic [7:0]  rom_data,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out
);

    state_e      state;
    logic        ph;
    logic [14:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [3:0]  cnt;
    logic [7:0]  gpio_s1;
    logic [7:0]  gpio_s2;
    logic [7:0]  ram_rdata;
    logic [7:0]  io_rdata;
    logic [3:0]  io_off;
    logic        ram_en;

    // Window is 16 bytes, so the low nibble difference is the full offset.
    assign io_off = addr_q[3:0] - IO_BASE[3:0];
    assign ram_en = (state == ST_RAM) && !ph;

    mem_ram_sp #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

`ifdef MEM_BUS_TIMER_EN
    logic [7:0] timer;
    logic       timer_wr;

    assign timer_wr = (state == ST_IO) && ph && we_q
                   && (io_off == IO_TIMER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= 8'h00;
        else if (timer_wr)
            timer <= wdata_q;
        else
            timer <= timer + 8'h01;
    end
`endif

    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            IO_GPIO_OUT: io_rdata = gpio_out;
            IO_GPIO_IN:  io_rdata = gpio_s2;
`ifdef MEM_BUS_TIMER_EN
            IO_TIMER:    io_rdata = timer;
`endif
            default:     io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_s1 <= 8'h00;
            gpio_s2 <= 8'h00;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ph        <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
            cnt       <= 4'd0;
            cpu_ack   <= 1'b0;
            bus_err   <= 1'b0;
            rom_rd    <= 1'b0;
            cpu_rdata <= 8'h00;
            rom_addr  <= '0;
            gpio_out  <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            bus_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr[14:0];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        ph      <= 1'b0;
                        case (decode_region(cpu_addr, IO_BASE))
                            REG_RAM: state <= ST_RAM;
                            REG_ROM: state <= ST_ROM;
                            default: state <= ST_IO;
                        endcase
                    end
                end
                ST_RAM: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        if (!we_q)
                            cpu_rdata <= ram_rdata;
                        cpu_ack <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ROM: begin
                    if (!ph) begin
                        ph <= 1'b1;
                        if (!we_q) begin
                            rom_rd   <= 1'b1;
                            rom_addr <= addr_q;
                            cnt      <= 4'(ROM_WAIT);
                        end
                    end else if (we_q) begin
                        cpu_ack <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= ST_ACK;
                    end else if (cnt == 4'd0) begin
                        cpu_rdata <= rom_data;
                        cpu_ack   <= 1'b1;
                        rom_rd    <= 1'b0;
                        state     <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_IO: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        if (!we_q)
                            cpu_rdata <= io_rdata;
                        else if (io_off == IO_GPIO_OUT)
                            gpio_out <= wdata_q;
                        cpu_ack <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; timer expectations
// follow MEM_BUS_TIMER_EN.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        bus_err;
    logic [14:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .bus_err   (bus_err),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One handshake; lat counts edges from the sampling edge to the ack.
    task automatic access(
        input  logic        we,
        input  logic [15:0] a,
        input  logic [7:0]  wd,
        output logic [7:0]  rd,
        output int          lat,
        output logic        err,
        output int          rom_cyc,
        output logic [14:0] ra
    );
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk);
        lat     = 0;
        rom_cyc = 0;
        ra      = '0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (rom_rd) begin
                rom_cyc++;
                ra = rom_addr;
            end
        end while (!cpu_ack && lat < 40);
        rd      = cpu_rdata;
        err     = bus_err;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(posedge clk);
    endtask

    logic [7:0]  rd;
    logic        err;
    logic [14:0] ra;
    int          lat;
    int          rc;
    int          acks;

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        rom_data  = 8'hA9;
        gpio_in   = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", int'(cpu_ack), 0);
        chk("rst_rom_rd", int'(rom_rd), 0);
        chk("rst_rdata", int'(cpu_rdata), 'h00);
        chk("rst_gpio_out", int'(gpio_out), 'h00);
        chk("rst_bus_err", int'(bus_err), 0);
        chk("rst_rom_addr", int'(rom_addr), 'h0000);
        @(negedge clk);
        reset = 1'b0;

        access(1'b1, 16'h0010, 8'h5A, rd, lat, err, rc, ra);
        chk("ram_wr_lat", lat, 2);
        chk("ram_wr_err", int'(err), 0);
        access(1'b0, 16'h0010, 8'h00, rd, lat, err, rc, ra);
        chk("ram_rd_lat", lat, 2);
        chk("ram_rd_data", int'(rd), 'h5A);
        chk("ram_rd_err", int'(err), 0);

        access(1'b0, 16'h8003, 8'h00, rd, lat, err, rc, ra);
        chk("rom_rd_lat", lat, 4);
        chk("rom_rd_data", int'(rd), 'hA9);
        chk("rom_rd_cycles", rc, 3);
        chk("rom_rd_addr", int'(ra), 'h0003);

        access(1'b1, 16'h9000, 8'h11, rd, lat, err, rc, ra);
        chk("rom_wr_lat", lat, 2);
        chk("rom_wr_err", int'(err), 1);
        chk("rom_wr_no_rd", rc, 0);
        chk("rom_wr_rdata", int'(rd), 'hA9);

        access(1'b1, 16'hFFF0, 8'hC3, rd, lat, err, rc, ra);
        chk("io_wr_lat", lat, 2);
        chk("io_wr_err", int'(err), 0);
        chk("gpio_out", int'(gpio_out), 'hC3);
        access(1'b0, 16'hFFF0, 8'h00, rd, lat, err, rc, ra);
        chk("io_rd_gpio_out", int'(rd), 'hC3);
        access(1'b0, 16'hFFF1, 8'h00, rd, lat, err, rc, ra);
        chk("io_rd_gpio_in", int'(rd), 'h3C);
        access(1'b0, 16'hFFF7, 8'h00, rd, lat, err, rc, ra);
        chk("io_rd_unused", int'(rd), 'h00);
        chk("io_rd_lat", lat, 2);

        access(1'b1, 16'h7FFF, 8'h81, rd, lat, err, rc, ra);
        access(1'b0, 16'h7FFF, 8'h00, rd, lat, err, rc, ra);
        chk("bnd_7fff_data", int'(rd), 'h81);
        chk("bnd_7fff_lat", lat, 2);
        chk("bnd_7fff_no_rom", rc, 0);
        rom_data = 8'h42;
        access(1'b0, 16'h8000, 8'h00, rd, lat, err, rc, ra);
        chk("bnd_8000_lat", lat, 4);
        chk("bnd_8000_data", int'(rd), 'h42);
        chk("bnd_8000_addr", int'(ra), 'h0000);
        rom_data = 8'h17;
        access(1'b0, 16'hFFEF, 8'h00, rd, lat, err, rc, ra);
        chk("bnd_ffef_lat", lat, 4);
        chk("bnd_ffef_addr", int'(ra), 'h7FEF);
        chk("bnd_ffef_data", int'(rd), 'h17);
        access(1'b0, 16'hFFFF, 8'h00, rd, lat, err, rc, ra);
        chk("bnd_ffff_lat", lat, 2);
        chk("bnd_ffff_data", int'(rd), 'h00);
        chk("bnd_ffff_no_rom", rc, 0);

        access(1'b0, 16'hFFF1, 8'h00, rd, lat, err, rc, ra);
        access(1'b1, 16'hFFF2, 8'hFE, rd, lat, err, rc, ra);
        access(1'b0, 16'hFFF2, 8'h00, rd, lat, err, rc, ra);
`ifdef MEM_BUS_TIMER_EN
        chk("timer_wrap", int'(rd), 'h01);
`else
        chk("timer_absent", int'(rd), 'h00);
`endif

        // Reset while the ROM access is in its wait cycles.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8003;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_rom_rd_busy", int'(rom_rd), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rom_rd", int'(rom_rd), 0);
        chk("mid_rst_gpio", int'(gpio_out), 'h00);
        chk("mid_rst_ack", int'(cpu_ack), 0);
        cpu_req = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (cpu_ack)
                acks++;
        end
        chk("mid_rst_no_ack", acks, 0);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 16'h0010, 8'h00, rd, lat, err, rc, ra);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", int'(rd), 'h5A);

        // Reset right after a RAM write is sampled must not write.
        access(1'b1, 16'h0020, 8'h11, rd, lat, err, rc, ra);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0020;
        cpu_wdata = 8'h22;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 16'h0020, 8'h00, rd, lat, err, rc, ra);
        chk("no_partial_wr", int'(rd), 'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
